// File: rtl/multicycle_sequencer_pkg.sv
// Shared control definitions for the RV32I multi-cycle datapath: the
// sequencer state encoding, base opcodes (also used by the opcode decoder)
// and next-PC select encodings.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  // Opcodes the sequencer knows how to step through (SYSTEM is handled apart).
  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory handshake between the sequencer (master) and the
// memory side of the datapath (slave).
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic ir_load;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, ir_load, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, ir_load, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer_seq_wait_timer.sv
// Memory wait-cycle counter. expired is high once TIMEOUT-1 waits have been
// counted, so a further not-ready cycle is the TIMEOUT-th wait.
module seq_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Count wait cycles, saturating at the limit; clear wins over count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + W'(1);
  end

  assign expired = (cnt == LIM);
endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes,
// retired-instruction counter and halt on SYSTEM, illegal opcode or timeout.
module multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  multicycle_sequencer_if.master mem,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     retired
);

  state_t state, state_next;
  logic   imem_req, ir_load, dmem_req, dmem_we;
  logic   retire, set_ill, set_to;
  logic   wait_clr, wait_en, wait_expired;

  wire is_load  = (opcode == OP_LOAD);
  wire is_store = (opcode == OP_STORE);

  // Restart the wait count on every state change; count not-ready cycles
  // only while actually waiting on a memory.
  assign wait_clr = (state_next != state);
  assign wait_en  = ((state == FETCH) && !mem.imem_ready) ||
                    ((state == MEM)   && !mem.dmem_ready);

  seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and strobe decode; ready wins over an expiring wait count.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    retire     = 1'b0;
    set_ill    = 1'b0;
    set_to     = 1'b0;
    case (state)
      IDLE: if (start) state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end else if (wait_expired) begin
          set_to     = 1'b1;
          state_next = HALT;
        end
      end
      DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_next = HALT;
        end else if (!op_legal(opcode)) begin
          set_ill    = 1'b1;
          state_next = HALT;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (opcode == OP_BRANCH) begin
          pc_we      = 1'b1;
          pc_sel     = branch_taken ? PC_BRANCH : PC_PLUS4;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (is_load || is_store) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (mem.dmem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (wait_expired) begin
          set_to     = 1'b1;
          state_next = HALT;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = (opcode == OP_JAL)  ? PC_JAL  :
                     (opcode == OP_JALR) ? PC_JALR : PC_PLUS4;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = HALT;
    endcase
  end

  // Sticky halt causes and the retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      retired     <= '0;
    end else begin
      if (set_ill) illegal     <= 1'b1;
      if (set_to)  timeout_err <= 1'b1;
      if (retire)  retired     <= retired + CNT_W'(1);
    end
  end

  assign busy         = (state != IDLE) && (state != HALT);
  assign halted       = (state == HALT);
  assign mem.imem_req = imem_req;
  assign mem.ir_load  = ir_load;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;

endmodule
